lcd_bus_decoder: RTL and testbench
==================================

LCD_BUS_DECODER -- requirements
Module: lcd_bus_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on all LCD bus inputs.
REQ-002 SHALL have parameter MIN_E_HIGH, default 3: minimum synchronized E-high cycles for a strobe to be accepted.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port lcd_rs  input  1  register select from the LCD master (0 = command, 1 = data).
REQ-006 SHALL have port lcd_rw  input  1  read/write from the master (1 = read).
REQ-007 SHALL have port lcd_e  input  1  enable strobe from the master.
REQ-008 SHALL have port lcd_d  input  4  data nibble from the master.
REQ-009 SHALL have port rd_addr  input  5  character buffer read address (0-15 = line 1, 16-31 = line 2).
REQ-010 SHALL have port rd_char  output  8  buffer[rd_addr], registered, 1-cycle latency.
REQ-011 SHALL have port byte_valid  output  1  1-cycle pulse per decoded byte.
REQ-012 SHALL have port byte_rs  output  1  RS of the decoded byte.
REQ-013 SHALL have port byte_data  output  8  decoded byte.
REQ-014 SHALL have port cursor  output  5  current buffer write index.
REQ-015 SHALL have port display_on  output  1  D bit of the last display-control command.
REQ-016 SHALL have port nibble_mode  output  1  1 once 4-bit mode is entered.
REQ-017 SHALL have port busy  output  1  high during clear.
REQ-018 SHALL have port overflow  output  1  sticky flag: a byte was dropped while busy.

Function
REQ-019 SHALL pass lcd_rs, lcd_rw, lcd_e and lcd_d through SYNC_STAGES flops before use.
REQ-020 SHALL count synchronized E-high cycles; on the E falling edge with count >= MIN_E_HIGH and rw=0, SHALL accept the RS/D values sampled in the last E-high cycle.
REQ-021 SHALL ignore strobes with count < MIN_E_HIGH and strobes with rw=1; these SHALL NOT advance the nibble phase.
REQ-022 SHALL implement a phase FSM with states WAKE, HI, LO; reset state SHALL be WAKE.
REQ-023 In WAKE, an accepted strobe SHALL form byte {d,4'h0} and emit it; d=4'h2 with rs=0 SHALL move to HI and set nibble_mode.
REQ-024 In HI, an accepted strobe SHALL store the high nibble and move to LO.
REQ-025 In LO, an accepted strobe SHALL complete the byte {hi,d}, emit it and move to HI.
REQ-026 A completed command byte with bits[7:4]=4'h3 SHALL return the FSM to WAKE and clear nibble_mode.
REQ-027 byte_valid SHALL pulse in the cycle after the accepted falling edge is detected, with byte_rs and byte_data valid in that cycle and held until the next byte.
REQ-028 Data byte: buffer[cursor] <= byte; cursor +1 (31 wraps to 0) when I/D=1, -1 (0 wraps to 31) when I/D=0.
REQ-029 Command 8'h01 (clear) SHALL set cursor=0 and I/D=1, then write 8'h20 to indices 0..31, one per cycle; busy SHALL be high for exactly 32 cycles.
REQ-030 Command 8'b000001xx SHALL latch I/D = bit1; command 8'b00001xxx SHALL latch display_on = bit2.
REQ-031 Command 8'h80|a: for a=0x00-0x0F cursor=a; for a=0x40-0x4F cursor=16+a[3:0]; any other a SHALL leave cursor unchanged.
REQ-032 Other commands SHALL be emitted on byte_valid with no further effect.
REQ-033 A byte completed while busy SHALL still be emitted on byte_valid, SHALL NOT change buffer or cursor, and SHALL set overflow.
REQ-034 A buffer write and an rd_addr read of the same index in the same cycle SHALL return the old value.

Reset
REQ-035 Reset SHALL set phase=WAKE, nibble_mode=0, cursor=0, I/D=1, display_on=0, busy=0, overflow=0, byte_valid=0, byte_rs=0, byte_data=0, rd_char=0, and clear the synchronizers.
REQ-036 Buffer contents SHALL NOT be cleared by reset; reset asserted mid-clear SHALL abort the clear.

Structure
REQ-037 A shared package lcd_pkg SHALL hold the phase enum and command constants (CLEAR, ENTRY, DISPCTL, FUNCSET, SETDDRAM) and the line-2 base 0x40.
REQ-038 SHALL instantiate one sub-module, lcd_char_ram: a 32x8 single-write, single-registered-read buffer.

Verification
REQ-039 Init 3,3,2 then 0x28 as nibbles 2,8 -> bytes 0x30,0x30,0x20,0x28; nibble_mode=1; phase=HI.
REQ-040 After init, set 0xC5, write data 0x41 -> buffer[21]=0x41, cursor=22.
REQ-041 Set 0xCF, write 0x42 -> cursor wraps 31->0; entry 0x04, set 0x80, write 0x43 -> buffer[0]=0x43, cursor=31.
REQ-042 Clear 0x01, then a data byte 10 cycles later -> busy high for 32 cycles; overflow=1; all rd_char values are 0x20.
REQ-043 E pulse 2 cycles wide (MIN_E_HIGH=3) and an rw=1 strobe -> no byte_valid and phase unchanged.
REQ-044 Reset asserted between the high and low nibble -> phase=WAKE and nibble_mode=0; buffer contents are retained.

Source files
------------

// File: rtl/lcd_pkg.sv
// ============================================================================
// lcd_pkg : shared types and command constants for the LCD bus decoder
// Rev 1.0
// ============================================================================
`default_nettype none

package lcd_pkg;

  typedef enum logic [1:0] {
    PH_WAKE = 2'd0,
    PH_HI   = 2'd1,
    PH_LO   = 2'd2
  } phase_t;

  typedef enum logic [2:0] {
    CK_OTHER    = 3'd0,
    CK_CLEAR    = 3'd1,
    CK_ENTRY    = 3'd2,
    CK_DISPCTL  = 3'd3,
    CK_FUNCSET  = 3'd4,
    CK_SETDDRAM = 3'd5
  } cmd_kind_t;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h04;
  localparam logic [7:0] CMD_DISPCTL  = 8'h08;
  localparam logic [7:0] CMD_FUNCSET  = 8'h20;
  localparam logic [7:0] CMD_SETDDRAM = 8'h80;
  localparam logic [6:0] LINE2_BASE   = 7'h40;
  localparam logic [7:0] CLEAR_CHAR   = 8'h20;
  localparam int         BUF_DEPTH    = 32;
  localparam int         BUF_AW       = 5;

  // Classify a command byte by its leading-one position (HD44780 style).
  function automatic cmd_kind_t cmd_kind(input logic [7:0] b);
    if (b == CMD_CLEAR)                          return CK_CLEAR;
    else if (b[7] == CMD_SETDDRAM[7])            return CK_SETDDRAM;
    else if (b[7:5] == CMD_FUNCSET[7:5])         return CK_FUNCSET;
    else if (b[7:3] == CMD_DISPCTL[7:3])         return CK_DISPCTL;
    else if (b[7:2] == CMD_ENTRY[7:2])           return CK_ENTRY;
    else                                         return CK_OTHER;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_char_ram.sv
// ============================================================================
// lcd_char_ram : 32x8 character buffer, one write port, one registered read
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_char_ram
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [BUF_AW-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [BUF_AW-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [BUF_DEPTH];

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/lcd_bus_decoder.sv
// ============================================================================
// lcd_bus_decoder : snoops an HD44780-style 4-bit bus and mirrors the display
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_bus_decoder
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_E_HIGH  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [3:0] lcd_d,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       byte_valid,
  output logic       byte_rs,
  output logic [7:0] byte_data,
  output logic [4:0] cursor,
  output logic       display_on,
  output logic       nibble_mode,
  output logic       busy,
  output logic       overflow
);

  localparam int             CNT_W = $clog2(MIN_E_HIGH + 1);
  localparam logic [CNT_W-1:0] E_MIN = CNT_W'(MIN_E_HIGH);

  logic [SYNC_STAGES-1:0][6:0] sync_pipe;
  logic                        s_rs, s_rw, s_e;
  logic [3:0]                  s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_d};
      for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
    end
  end

  assign {s_rs, s_rw, s_e, s_d} = sync_pipe[SYNC_STAGES-1];

  // Strobe qualification: the count saturates at the threshold.
  logic             e_prev;
  logic [CNT_W-1:0] e_cnt;
  logic             smp_rs, smp_rw;
  logic [3:0]       smp_d;
  logic             accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_prev <= 1'b0;
      e_cnt  <= '0;
      smp_rs <= 1'b0;
      smp_rw <= 1'b0;
      smp_d  <= 4'h0;
    end else begin
      e_prev <= s_e;
      if (s_e) begin
        if (e_cnt != E_MIN) e_cnt <= e_cnt + 1'b1;
        smp_rs <= s_rs;
        smp_rw <= s_rw;
        smp_d  <= s_d;
      end else begin
        e_cnt <= '0;
      end
    end
  end

  assign accept = e_prev && !s_e && (e_cnt >= E_MIN) && !smp_rw;

  phase_t     phase, phase_next;
  logic [3:0] hi_nib;
  logic       emit;
  logic [7:0] new_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= PH_WAKE;
      hi_nib <= 4'h0;
    end else begin
      phase <= phase_next;
      if (accept && phase == PH_HI) hi_nib <= smp_d;
    end
  end

  always_comb begin
    phase_next = phase;
    emit       = 1'b0;
    new_byte   = {smp_d, 4'h0};
    if (accept) begin
      case (phase)
        PH_WAKE: begin
          emit = 1'b1;
          if (!smp_rs && smp_d == 4'h2) phase_next = PH_HI;
        end
        PH_HI: phase_next = PH_LO;
        PH_LO: begin
          emit     = 1'b1;
          new_byte = {hi_nib, smp_d};
          // A function-set with DL=1 drops the controller back to 8-bit wake-up.
          phase_next = (!smp_rs && hi_nib == 4'h3) ? PH_WAKE : PH_HI;
        end
        default: phase_next = PH_WAKE;
      endcase
    end
  end

  assign nibble_mode = (phase != PH_WAKE);

  logic       inc;
  logic [4:0] clr_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_valid <= 1'b0;
      byte_rs    <= 1'b0;
      byte_data  <= 8'h00;
      cursor     <= 5'd0;
      inc        <= 1'b1;
      display_on <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      clr_idx    <= 5'd0;
    end else begin
      byte_valid <= emit;
      if (emit) begin
        byte_rs   <= smp_rs;
        byte_data <= new_byte;
      end
      if (busy) begin
        clr_idx <= clr_idx + 5'd1;
        if (clr_idx == 5'd31) busy <= 1'b0;
      end
      if (emit) begin
        if (busy) begin
          overflow <= 1'b1;
        end else if (smp_rs) begin
          cursor <= inc ? cursor + 5'd1 : cursor - 5'd1;
        end else begin
          case (cmd_kind(new_byte))
            CK_CLEAR: begin
              cursor  <= 5'd0;
              inc     <= 1'b1;
              busy    <= 1'b1;
              clr_idx <= 5'd0;
            end
            CK_ENTRY:   inc        <= new_byte[1];
            CK_DISPCTL: display_on <= new_byte[2];
            CK_SETDDRAM: begin
              if (new_byte[6:4] == 3'b000)
                cursor <= {1'b0, new_byte[3:0]};
              else if (new_byte[6:4] == LINE2_BASE[6:4])
                cursor <= {1'b1, new_byte[3:0]};
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;

  // The clear sweep owns the write port; incoming data is dropped meanwhile.
  assign ram_we    = busy || (emit && smp_rs);
  assign ram_waddr = busy ? clr_idx : cursor;
  assign ram_wdata = busy ? CLEAR_CHAR : new_byte;

  lcd_char_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr),
    .rdata (rd_char)
  );

endmodule

`default_nettype wire

// File: tb/tb_lcd_bus_decoder.sv
// ============================================================================
// tb_lcd_bus_decoder : random and directed LCD bus traffic vs. behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lcd_bus_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic [3:0] lcd_d = 4'h0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       byte_valid, byte_rs;
  logic [7:0] byte_data;
  logic [4:0] cursor;
  logic       display_on, nibble_mode, busy, overflow;

  lcd_bus_decoder #(.SYNC_STAGES(2), .MIN_E_HIGH(3)) dut (
    .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_d(lcd_d), .rd_addr(rd_addr), .rd_char(rd_char), .byte_valid(byte_valid),
    .byte_rs(byte_rs), .byte_data(byte_data), .cursor(cursor),
    .display_on(display_on), .nibble_mode(nibble_mode), .busy(busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [8:0] obs_q[$];
  int         busy_cycles = 0;

  always @(negedge clk) begin
    if (byte_valid) obs_q.push_back({byte_rs, byte_data});
    if (busy) busy_cycles++;
  end

  // Behavioural model of the mirrored controller.
  int         m_phase;
  logic [3:0] m_hi;
  int         m_cur;
  bit         m_id, m_disp, m_ovf, m_busy;
  logic [7:0] m_mem [32];
  logic [8:0] exp_q[$];

  task automatic m_reset();
    m_phase = 0; m_hi = 4'h0; m_cur = 0; m_id = 1; m_disp = 0; m_ovf = 0; m_busy = 0;
  endtask

  task automatic m_emit(input bit rs, input logic [7:0] b);
    int a;
    exp_q.push_back({rs, b});
    if (m_busy) begin
      m_ovf = 1;
      return;
    end
    if (rs) begin
      m_mem[m_cur] = b;
      m_cur = m_id ? (m_cur + 1) % 32 : (m_cur + 31) % 32;
    end else if (b == 8'h01) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 8'h20;
      m_cur = 0; m_id = 1; m_busy = 1;
    end else if (b >= 8'h80) begin
      a = int'(b) - 128;
      if (a <= 15) m_cur = a;
      else if (a >= 64 && a <= 79) m_cur = 16 + a - 64;
    end else if (b >= 8'h08 && b <= 8'h0F) begin
      m_disp = b[2];
    end else if (b >= 8'h04 && b <= 8'h07) begin
      m_id = b[1];
    end
  endtask

  task automatic m_accept(input bit rs, input logic [3:0] d);
    case (m_phase)
      0: begin
        m_emit(rs, {d, 4'h0});
        if (!rs && d == 4'h2) m_phase = 1;
      end
      1: begin
        m_hi = d; m_phase = 2;
      end
      default: begin
        m_emit(rs, {m_hi, d});
        m_phase = (!rs && m_hi == 4'h3) ? 0 : 1;
      end
    endcase
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit rs, input bit rw, input logic [3:0] d, input int w);
    lcd_rs = rs; lcd_rw = rw; lcd_d = d; lcd_e = 1'b1;
    tick(w);
    lcd_e = 1'b0;
    tick(6);
    if (w >= 3 && !rw) m_accept(rs, d);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    strobe(rs, 1'b0, b[7:4], 4);
    strobe(rs, 1'b0, b[3:0], 4);
  endtask

  task automatic compare_bytes(input string tag);
    logic [8:0] e;
    logic [31:0] got;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (obs_q.size() > 0) ? 32'(obs_q.pop_front()) : 32'hFFFF_FFFF;
      check(tag, got, 32'(e));
    end
    check({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
    obs_q.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_cursor"}, 32'(cursor), 32'(m_cur));
    check({tag, "_nibble"}, 32'(nibble_mode), 32'(m_phase != 0));
    check({tag, "_disp"}, 32'(display_on), 32'(m_disp));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic read_check(input int addr, input logic [7:0] exp, input string tag);
    rd_addr = 5'(addr);
    tick(1);
    @(negedge clk);
    check(tag, 32'(rd_char), 32'(exp));
  endtask

  initial begin
    m_reset();
    tick(3);
    @(negedge clk);
    check("rst_rd_char", 32'(rd_char), 32'h0);
    check("rst_valid", 32'(byte_valid), 32'h0);
    check("rst_data", 32'({byte_rs, byte_data}), 32'h0);
    check("rst_cursor", 32'(cursor), 32'h0);
    check("rst_flags", 32'({display_on, nibble_mode, busy, overflow}), 32'h0);
    tick(1);
    reset = 1'b0;
    tick(2);

    // 8-bit wake-up, switch to 4-bit, then function set 0x28
    strobe(0, 0, 4'h3, 4);
    strobe(0, 0, 4'h3, 4);
    strobe(0, 0, 4'h2, 4);
    send_byte(0, 8'h28);
    compare_bytes("init");
    check("init_nibble", 32'(nibble_mode), 32'h1);
    check_state("init");

    send_byte(0, 8'hC5);
    send_byte(1, 8'h41);
    compare_bytes("c5");
    check("c5_cursor22", 32'(cursor), 32'd22);
    read_check(21, 8'h41, "buf21");

    send_byte(0, 8'hCF);
    send_byte(1, 8'h42);
    check("wrap_cursor0", 32'(cursor), 32'd0);
    send_byte(0, 8'h04);
    send_byte(0, 8'h80);
    send_byte(1, 8'h43);
    compare_bytes("dec");
    check("dec_cursor31", 32'(cursor), 32'd31);
    read_check(0, 8'h43, "buf0");
    read_check(31, 8'h42, "buf31");

    send_byte(0, 8'h0C);
    compare_bytes("dispctl");
    check_state("dispctl");

    // Clear, then a data byte that lands inside the busy window
    busy_cycles = 0;
    send_byte(0, 8'h01);
    tick(4);
    send_byte(1, 8'h55);
    tick(40);
    m_busy = 0;
    check("busy_len", 32'(busy_cycles), 32'd32);
    check("clr_ovf", 32'(overflow), 32'h1);
    compare_bytes("clear");
    check_state("clear");
    for (int i = 0; i < 32; i++) read_check(i, 8'h20, "clr_buf");

    // Short strobe and read strobe must be invisible
    strobe(1, 0, 4'h7, 2);
    strobe(1, 1, 4'h9, 4);
    check("reject_none", 32'(obs_q.size()), 32'd0);
    send_byte(1, 8'h6A);
    compare_bytes("reject_after");
    check_state("reject");

    for (int n = 0; n < 200; n++) begin
      bit rs, rw;
      int w;
      rs = 1'($urandom_range(0, 1));
      rw = ($urandom_range(0, 7) == 0);
      w  = int'($urandom_range(1, 5));
      strobe(rs, rw, 4'($urandom_range(0, 15)), w);
      if (m_busy) begin
        tick(40);
        m_busy = 0;
      end
      compare_bytes("rand");
      check_state("rand");
    end
    for (int i = 0; i < 32; i++) read_check(i, m_mem[i], "rand_buf");

    // Reset between the high and low nibble
    if (m_phase == 0) strobe(0, 0, 4'h2, 4);
    else if (m_phase == 2) strobe(1, 0, 4'h0, 4);
    compare_bytes("pre_rst");
    strobe(1, 0, 4'h4, 4);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    m_reset();
    tick(1);
    check("mid_rst_nibble", 32'(nibble_mode), 32'h0);
    check_state("mid_rst");
    for (int i = 0; i < 32; i++) read_check(i, m_mem[i], "rst_buf");
    strobe(0, 0, 4'h3, 4);
    compare_bytes("wake_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
